// File: rtl/uart_rx_os16_if.sv
// Consumer-side bus of the 16x oversampling UART receiver.
// Optional UART_RX_PARITY_EN adds the parity_err pulse.
interface uart_rx_os16_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  modport master (
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_err,
    output overrun,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_err,
    input  overrun,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_os16.sv
// UART receiver, 8N1 LSB first, 16x oversampling with 3-sample majority per bit.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse.
module uart_rx_os16 #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           rs232_rx,
  uart_rx_os16_if.master rx_if
);

  localparam int unsigned DIV  = CLK_HZ / (16 * BAUD);
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q;
  logic            prev_q;
  logic [DivW-1:0] div_q, div_d;
  logic [3:0]      idx_q, idx_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [1:0]      samp_q, samp_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            parity_err_q, parity_err_d;
`endif

  logic line, fall, tick, decide, bit_done, maj, good;

  assign line     = sync_q[1];
  assign fall     = prev_q & ~line;
  assign tick     = (state_q != StIdle) && (div_q == DivMax);
  assign decide   = tick && (idx_q == 4'd9);
  assign bit_done = tick && (idx_q == 4'd15);
  // Third sample is the live line at tick 9, so the vote completes on that tick.
  assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & line) | (samp_q[1] & line);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rs232_rx};
      prev_q <= line;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      div_q       <= '0;
      idx_q       <= '0;
      bit_cnt_q   <= '0;
      samp_q      <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      bit_cnt_q   <= bit_cnt_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    idx_d       = idx_q;
    bit_cnt_d   = bit_cnt_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_if.rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    good        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif

    if (state_q != StIdle) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) idx_d = idx_q + 4'd1;
      if (tick && idx_q == 4'd7) samp_d[0] = line;
      if (tick && idx_q == 4'd8) samp_d[1] = line;
    end

    unique case (state_q)
      StIdle: begin
        div_d = '0;
        idx_d = '0;
        if (fall) state_d = StStart;
      end
      StStart: begin
        if (decide && maj) begin
          state_d = StIdle;
        end else if (bit_done) begin
          state_d   = StData;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (decide) shift_d[bit_cnt_q] = maj;
        if (bit_done) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (decide) par_d = maj;
        if (bit_done) state_d = StStop;
      end
`endif
      StStop: begin
        if (decide) begin
          // Leave at mid-stop so a back-to-back start edge is not missed.
          state_d = StIdle;
          good    = maj;
          if (!maj) frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (par_q != ^shift_q) begin
            parity_err_d = 1'b1;
            good         = 1'b0;
          end
`endif
          if (good) begin
            if (!rx_valid_q || rx_if.rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.rx_busy   = (state_q != StIdle);
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed plus randomized bench for uart_rx_os16 with a frame-level reference model.
module tb_uart_rx_os16;
  localparam int BitClk = 160;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rs232_rx = 1'b1;

  uart_rx_os16_if rx_if ();

  uart_rx_os16 #(
    .CLK_HZ(1600000),
    .BAUD  (10000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rs232_rx(rs232_rx),
    .rx_if   (rx_if)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Observed events, collected away from the active edge.
  int         valid_rise = 0;
  int         valid_hi = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         pe_cnt = 0;
  logic       valid_prev = 1'b0;
  logic       busy_at_rise = 1'b1;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (rx_if.rx_valid && !valid_prev) begin
      valid_rise   <= valid_rise + 1;
      busy_at_rise <= rx_if.rx_busy;
    end
    if (rx_if.rx_valid) valid_hi <= valid_hi + 1;
    if (rx_if.frame_err) fe_cnt <= fe_cnt + 1;
    if (rx_if.overrun) ov_cnt <= ov_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (rx_if.parity_err) pe_cnt <= pe_cnt + 1;
`endif
    if (rx_if.rx_valid && rx_if.rx_ready) got_q.push_back(rx_if.rx_data);
    valid_prev <= rx_if.rx_valid;
  end

  // Reference model: one pending byte slot and expected event counts.
  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] exp_q[$];
  int         exp_fe = 0;
  int         exp_ov = 0;
  int         exp_pe = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ready(input logic v);
    rx_if.rx_ready = v;
    if (v && m_valid) begin
      exp_q.push_back(m_data);
      m_valid = 1'b0;
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input bit stop, input bit par_flip);
    bit ok;
    ok = stop;
    if (!stop) exp_fe++;
`ifdef UART_RX_PARITY_EN
    if (par_flip) begin
      exp_pe++;
      ok = 1'b0;
    end
`endif
    if (ok) begin
      if (!m_valid || rx_if.rx_ready) begin
        m_data  = d;
        m_valid = 1'b1;
      end else begin
        exp_ov++;
      end
    end
    if (m_valid && rx_if.rx_ready) begin
      exp_q.push_back(m_data);
      m_valid = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, rx_if.rx_valid, 0);
    check({tag, "_data"}, rx_if.rx_data, 0);
    check({tag, "_busy"}, rx_if.rx_busy, 0);
    check({tag, "_ferr"}, rx_if.frame_err, 0);
    check({tag, "_ovr"}, rx_if.overrun, 0);
  endtask

  // Drives one frame; spike inverts one clk near sample 8 of each data bit,
  // rst_at >= 0 pulses reset at that cycle and abandons the frame.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_flip,
                            input bit spike, input int rst_at);
    logic [10:0] fr;
    int          nbits;
    int          cyc;
    logic        v;
    fr       = '1;
    fr[0]    = 1'b0;
    fr[8:1]  = d;
`ifdef UART_RX_PARITY_EN
    fr[9]    = (^d) ^ par_flip;
    fr[10]   = stop;
    nbits    = 11;
`else
    fr[9]    = stop;
    nbits    = 10;
`endif
    cyc = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < BitClk; c++) begin
        v = fr[b];
        if (spike && b >= 1 && b <= 8 && c == 90) v = ~v;
        rs232_rx = v;
        if (cyc == rst_at) begin
          rst_n   = 1'b0;
          m_valid = 1'b0;
        end
        if (rst_at >= 0 && cyc == rst_at + 4) check_reset_values("midrst");
        if (rst_at >= 0 && cyc == rst_at + 8) rst_n = 1'b1;
        step(1);
        cyc++;
      end
    end
    rs232_rx = 1'b1;
    if (rst_at < 0) model_frame(d, stop, par_flip);
  endtask

  task automatic check_outcome(input string tag);
    step(3);
    check({tag, "_nacc"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_acc"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
    check({tag, "_fe"}, fe_cnt, exp_fe);
    check({tag, "_ov"}, ov_cnt, exp_ov);
    check({tag, "_pe"}, pe_cnt, exp_pe);
    check({tag, "_valid"}, rx_if.rx_valid, m_valid);
    if (m_valid) check({tag, "_data"}, rx_if.rx_data, m_data);
  endtask

  initial begin
    int         r0;
    int         h0;
    logic [7:0] d;
    bit         stop;
    bit         pf;

    rx_if.rx_ready = 1'b0;
    step(3);
    check_reset_values("reset");
    rst_n = 1'b1;
    step(5);

    // Single byte with consumer ready.
    set_ready(1'b1);
    r0 = valid_rise;
    h0 = valid_hi;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, -1);
    check_outcome("a5");
    check("a5_rise", valid_rise - r0, 1);
    check("a5_hiclk", valid_hi - h0, 1);
    check("a5_busy_at_rise", busy_at_rise, 0);

    // Back-to-back with consumer stalled.
    set_ready(1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, -1);
    check("b2b_first_valid", rx_if.rx_valid, 1);
    check("b2b_first_data", rx_if.rx_data, 8'h3C);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, -1);
    check_outcome("b2b");
    set_ready(1'b1);
    step(2);
    check("b2b_cleared", rx_if.rx_valid, 0);
    check_outcome("b2b_drain");

    // Framing error, then a good byte.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, -1);
    step(20);
    check_outcome("ferr");
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, -1);
    check_outcome("after_ferr");

    // Short low glitch on the idle line.
    r0 = valid_rise;
    rs232_rx = 1'b0;
    step(40);
    check("glitch_busy", rx_if.rx_busy, 1);
    rs232_rx = 1'b1;
    step(160);
    check("glitch_idle", rx_if.rx_busy, 0);
    check("glitch_rise", valid_rise - r0, 0);
    check_outcome("glitch");

    // One-clk spike in every data bit.
    send_frame(8'h0F, 1'b1, 1'b0, 1'b1, -1);
    check_outcome("spike");

    // Reset during bit 4 of 0xFF, then a clean byte.
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 5 * BitClk + 20);
    check("rst_after_valid", rx_if.rx_valid, 0);
    check("rst_after_busy", rx_if.rx_busy, 0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0, -1);
    check_outcome("after_rst");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, -1);
    check_outcome("parity");
`endif

    // Randomized frames, stop bits, consumer stalls and gaps.
    for (int i = 0; i < 8; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      pf   = 1'b0;
`ifdef UART_RX_PARITY_EN
      pf   = ($urandom_range(0, 3) == 0);
`endif
      set_ready(1'($urandom_range(0, 1)));
      send_frame(d, stop, pf, 1'b0, -1);
      if (!stop) step(20 + $urandom_range(0, 30));
      else step($urandom_range(0, 30));
    end
    check_outcome("rand");
    set_ready(1'b1);
    check_outcome("rand_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
